// File: rtl/rec_tq_pkg.sv
// Shared rec_tq definitions: transform-size encodings, packer FSM states and lane mapping helpers.
package rec_tq_pkg;

    localparam int OUT_W_DEFAULT = 19;
    localparam int NUM_LANES     = 32;

    typedef enum logic [1:0] {
        TS_4  = 2'd0,
        TS_8  = 2'd1,
        TS_16 = 2'd2,
        TS_32 = 2'd3
    } ts_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_WAIT = 2'd2
    } pack_state_e;

    function automatic logic [3:0] beatsPerSize(ts_e size);
        case (size)
            TS_4:    return 4'd4;
            TS_8:    return 4'd2;
            TS_16:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // 4x4 places each beat as its own row at a stride of 8 lanes; larger sizes fill lanes linearly.
    function automatic logic [4:0] laneIdx(ts_e size, logic [2:0] beat, logic [1:0] lane);
        if (size == TS_4)
            return {beat[1:0], 1'b0, lane};
        else
            return {beat, lane};
    endfunction

endpackage

// File: rtl/re_coef_pack_if.sv
// Handshake/data bundle between the coefficient source, the packer and the inverse-transform selector.
// Carries i_zero only when RE_PACK_ZERO_EN is defined.
interface re_coef_pack_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 19
);
    logic                  i_valid;
    logic                  o_ready;
    logic                  i_start;
    logic [1:0]            i_transize;
    logic [1:0]            i_tq_sel;
    logic [4*IN_W-1:0]     i_data;
`ifdef RE_PACK_ZERO_EN
    logic                  i_zero;
`endif
    logic                  o_valid;
    logic                  i_ready;
    logic [1:0]            o_transize;
    logic [1:0]            o_tq_sel;
    logic [32*OUT_W-1:0]   o_data;
    logic                  o_err;

    modport master (
`ifdef RE_PACK_ZERO_EN
        output i_zero,
`endif
        output i_valid, i_start, i_transize, i_tq_sel, i_data, i_ready,
        input  o_ready, o_valid, o_transize, o_tq_sel, o_data, o_err
    );

    modport slave (
`ifdef RE_PACK_ZERO_EN
        input  i_zero,
`endif
        input  i_valid, i_start, i_transize, i_tq_sel, i_data, i_ready,
        output o_ready, o_valid, o_transize, o_tq_sel, o_data, o_err
    );

endinterface

// File: rtl/re_pack_buf.sv
// One ping-pong entry: 32 output lanes plus size/tq_sel, cleared on open, written 4 lanes per beat.
module re_pack_buf
    import rec_tq_pkg::*;
#(
    parameter int OUT_W    = OUT_W_DEFAULT,
    parameter int WR_LANES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_open,
    input  logic                           i_write,
    input  logic                           i_setFull,
    input  logic                           i_pop,
    input  ts_e                            i_transize,
    input  logic [1:0]                     i_tqSel,
    input  logic [WR_LANES-1:0][4:0]       i_wrLane,
    input  logic [WR_LANES-1:0][OUT_W-1:0] i_wrData,
    output logic [NUM_LANES*OUT_W-1:0]     o_data,
    output ts_e                            o_transize,
    output logic [1:0]                     o_tqSel,
    output logic                           o_full
);

    logic [NUM_LANES-1:0][OUT_W-1:0] r_data;
    ts_e                             r_transize;
    logic [1:0]                      r_tqSel;
    logic                            r_full;

    // Opening and writing may coincide on a group's first beat; the lane writes land on the cleared row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_transize <= TS_4;
            r_tqSel    <= '0;
            r_full     <= 1'b0;
        end else begin
            if (i_open) begin
                r_data     <= '0;
                r_transize <= i_transize;
                r_tqSel    <= i_tqSel;
            end
            if (i_write) begin
                for (int j = 0; j < WR_LANES; j++)
                    r_data[i_wrLane[j]] <= i_wrData[j];
            end
            if (i_setFull)
                r_full <= 1'b1;
            else if (i_pop)
                r_full <= 1'b0;
        end
    end

    assign o_data     = r_data;
    assign o_transize = r_transize;
    assign o_tqSel    = r_tqSel;
    assign o_full     = r_full;

endmodule

// File: rtl/re_coef_pack.sv
// Packs a 4-wide dequantized coefficient stream into 32-lane rows through a ping-pong buffer pair.
// Optional RE_PACK_ZERO_EN: a start beat with i_zero completes an all-zero group on its own.
module re_coef_pack
    import rec_tq_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = OUT_W_DEFAULT,
    parameter int IN_LANES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    re_coef_pack_if.slave bus
);

    pack_state_e r_state, w_nextState;
    logic [2:0]  r_count, w_nextCount;
    ts_e         r_curSize;
    logic        r_wrPtr, r_rdPtr, r_err;

    logic        w_accept, w_start, w_zero, w_pop, w_valid, w_done, w_otherBusy;
    logic        w_open, w_write, w_setFull, w_err;
    logic [2:0]  w_beat;
    ts_e         w_size;
    logic [1:0]  w_full;
    ts_e         w_bufSize [2];
    logic [1:0]  w_bufTq   [2];
    logic [NUM_LANES*OUT_W-1:0]     w_bufData [2];
    logic [IN_LANES-1:0][4:0]       w_wrLane;
    logic [IN_LANES-1:0][OUT_W-1:0] w_wrData;

    assign bus.o_ready = !w_full[r_wrPtr];
    assign w_valid     = w_full[r_rdPtr];
    assign w_pop       = w_valid && bus.i_ready;
    assign w_accept    = bus.i_valid && bus.o_ready;
    assign w_start     = bus.i_start;
`ifdef RE_PACK_ZERO_EN
    assign w_zero      = bus.i_start && bus.i_zero;
`else
    assign w_zero      = 1'b0;
`endif
    assign w_beat      = w_start ? 3'd0 : r_count;
    assign w_size      = w_start ? ts_e'(bus.i_transize) : r_curSize;
    assign w_done      = w_zero || (({1'b0, w_beat} + 4'd1) == beatsPerSize(w_size));
    // The other entry only blocks us if it is not being popped in this same cycle.
    assign w_otherBusy = w_full[~r_wrPtr] && !(w_pop && (r_rdPtr != r_wrPtr));

    always_comb begin
        for (int j = 0; j < IN_LANES; j++) begin
            w_wrLane[j] = laneIdx(w_size, w_beat, 2'(j));
            w_wrData[j] = OUT_W'($signed(bus.i_data[j*IN_W +: IN_W]));
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_open      = 1'b0;
        w_write     = 1'b0;
        w_setFull   = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE, S_FILL: begin
                if (w_accept) begin
                    if (w_start || (r_state == S_FILL)) begin
                        w_open  = w_start;
                        w_write = !w_zero;
                        w_err   = w_start && (r_state == S_FILL);
                        if (w_done) begin
                            w_setFull   = 1'b1;
                            w_nextCount = 3'd0;
                            w_nextState = w_otherBusy ? S_WAIT : S_IDLE;
                        end else begin
                            w_nextCount = w_beat + 3'd1;
                            w_nextState = S_FILL;
                        end
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (w_pop)
                    w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= 3'd0;
            r_curSize <= TS_4;
            r_wrPtr   <= 1'b0;
            r_rdPtr   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            r_err   <= w_err;
            if (w_open)
                r_curSize <= w_size;
            if (w_setFull)
                r_wrPtr <= ~r_wrPtr;
            if (w_pop)
                r_rdPtr <= ~r_rdPtr;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_buf
        re_pack_buf #(
            .OUT_W    (OUT_W),
            .WR_LANES (IN_LANES)
        ) u_buf (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_open     (w_open    && (r_wrPtr == 1'(k))),
            .i_write    (w_write   && (r_wrPtr == 1'(k))),
            .i_setFull  (w_setFull && (r_wrPtr == 1'(k))),
            .i_pop      (w_pop     && (r_rdPtr == 1'(k))),
            .i_transize (w_size),
            .i_tqSel    (bus.i_tq_sel),
            .i_wrLane   (w_wrLane),
            .i_wrData   (w_wrData),
            .o_data     (w_bufData[k]),
            .o_transize (w_bufSize[k]),
            .o_tqSel    (w_bufTq[k]),
            .o_full     (w_full[k])
        );
    end

    assign bus.o_valid    = w_valid;
    assign bus.o_data     = w_bufData[r_rdPtr];
    assign bus.o_transize = w_bufSize[r_rdPtr];
    assign bus.o_tq_sel   = w_bufTq[r_rdPtr];
    assign bus.o_err      = r_err;

endmodule

// File: tb/tb_re_coef_pack.sv
// Directed bench for re_coef_pack: scoreboard of expected row vectors popped as the DUT presents them.
// Exercises the RE_PACK_ZERO_EN path when that macro is defined.
module tb_re_coef_pack;

    localparam int IN_W  = 16;
    localparam int OUT_W = 19;
    localparam int VW    = 32 * OUT_W;

    typedef struct {
        logic [VW-1:0] data;
        logic [1:0]    ts;
        logic [1:0]    tq;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t expQ[$];
    exp_t monE;
    exp_t ex;
    int   errors = 0;
    int   checks = 0;
    int   vecCount = 0;
    int   pushedCount = 0;

    re_coef_pack_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    re_coef_pack #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .IN_LANES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*IN_W-1:0] mkBeat(input int base);
        logic [4*IN_W-1:0] b;
        for (int j = 0; j < 4; j++)
            b[j*IN_W +: IN_W] = 16'(base + j);
        return b;
    endfunction

    function automatic exp_t expLinear(input logic [1:0] ts, input logic [1:0] tq, input int base, input int nBeats);
        exp_t e;
        e.data = '0;
        e.ts   = ts;
        e.tq   = tq;
        for (int c = 0; c < 4 * nBeats; c++)
            e.data[c*OUT_W +: OUT_W] = 19'(base + c);
        return e;
    endfunction

    // Drives one beat, holds it until o_ready is seen, and returns #1 after the accepting edge.
    task automatic applyStimulus(input logic start, input logic [1:0] ts, input logic [1:0] tq,
                                 input logic [4*IN_W-1:0] data);
        int waitCycles = 0;
        bus.i_valid    = 1'b1;
        bus.i_start    = start;
        bus.i_transize = ts;
        bus.i_tq_sel   = tq;
        bus.i_data     = data;
        @(negedge clk);
        while (!bus.o_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!bus.o_ready)
            checkOutput("readyTimeout", VW'(bus.o_ready), VW'(1));
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_start = 1'b0;
    endtask

    task automatic applyGroup(input logic [1:0] ts, input logic [1:0] tq, input int base, input int nBeats);
        expQ.push_back(expLinear(ts, tq, base, nBeats));
        pushedCount++;
        for (int b = 0; b < nBeats; b++)
            applyStimulus(b == 0, ts, tq, mkBeat(base + 4 * b));
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (expQ.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, VW'(expQ.size()), '0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.o_valid && bus.i_ready) begin
            vecCount++;
            if (expQ.size() == 0) begin
                checkOutput("vecUnexpected", VW'(bus.o_valid), VW'(0));
            end else begin
                monE = expQ.pop_front();
                checkOutput("vecData", bus.o_data, monE.data);
                checkOutput("vecTransize", VW'(bus.o_transize), VW'(monE.ts));
                checkOutput("vecTqSel", VW'(bus.o_tq_sel), VW'(monE.tq));
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_start    = 1'b0;
        bus.i_transize = 2'd0;
        bus.i_tq_sel   = 2'd0;
        bus.i_data     = '0;
        bus.i_ready    = 1'b1;
`ifdef RE_PACK_ZERO_EN
        bus.i_zero     = 1'b0;
`endif
        #12;
        checkOutput("rstValid", VW'(bus.o_valid), VW'(0));
        checkOutput("rstErr", VW'(bus.o_err), VW'(0));
        checkOutput("rstTransize", VW'(bus.o_transize), VW'(0));
        checkOutput("rstTqSel", VW'(bus.o_tq_sel), VW'(0));
        checkOutput("rstData", bus.o_data, '0);
        checkOutput("rstReady", VW'(bus.o_ready), VW'(1));
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] 32x32 group, values c-16");
        expQ.push_back(expLinear(2'd3, 2'd1, -16, 8));
        pushedCount++;
        for (int b = 0; b < 8; b++) begin
            if (b == 7)
                checkOutput("t32 noEarlyValid", VW'(bus.o_valid), VW'(0));
            applyStimulus(b == 0, 2'd3, 2'd1, mkBeat(-16 + 4 * b));
        end
        checkOutput("t32 latency", VW'(bus.o_valid), VW'(1));
        checkOutput("t32 transize", VW'(bus.o_transize), VW'(3));
        waitDrain("t32 drained");

        $display("[TB] 4x4 group, four rows at stride 8");
        ex.data = '0;
        ex.ts   = 2'd0;
        ex.tq   = 2'd0;
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < 4; j++)
                ex.data[(8*b + j)*OUT_W +: OUT_W] = 19'(10*b + j);
        expQ.push_back(ex);
        pushedCount++;
        for (int b = 0; b < 4; b++)
            applyStimulus(b == 0, 2'd0, 2'd0, mkBeat(10 * b));
        waitDrain("t4x4 drained");

        $display("[TB] back-pressure with three 8x8 groups");
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        applyGroup(2'd1, 2'd2, 100, 2);
        applyGroup(2'd1, 2'd3, 200, 2);
        checkOutput("bp readyLow", VW'(bus.o_ready), VW'(0));
        checkOutput("bp validHigh", VW'(bus.o_valid), VW'(1));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("bp holdData", bus.o_data, expQ[0].data);
            checkOutput("bp holdReady", VW'(bus.o_ready), VW'(0));
        end
        bus.i_ready = 1'b1;
        applyGroup(2'd1, 2'd1, -300, 2);
        waitDrain("bp drained");
        checkOutput("bp vecCount", VW'(vecCount), VW'(pushedCount));

        $display("[TB] restart mid 16x16 group and stray beat");
        applyStimulus(1'b1, 2'd2, 2'd3, mkBeat(1000));
        applyStimulus(1'b0, 2'd2, 2'd3, mkBeat(1004));
        checkOutput("restart noErrMid", VW'(bus.o_err), VW'(0));
        expQ.push_back(expLinear(2'd2, 2'd2, 2000, 4));
        pushedCount++;
        applyStimulus(1'b1, 2'd2, 2'd2, mkBeat(2000));
        checkOutput("restart errPulse", VW'(bus.o_err), VW'(1));
        applyStimulus(1'b0, 2'd2, 2'd2, mkBeat(2004));
        checkOutput("restart errCleared", VW'(bus.o_err), VW'(0));
        applyStimulus(1'b0, 2'd2, 2'd2, mkBeat(2008));
        applyStimulus(1'b0, 2'd2, 2'd2, mkBeat(2012));
        waitDrain("restart drained");
        applyStimulus(1'b0, 2'd1, 2'd1, mkBeat(7));
        checkOutput("stray errPulse", VW'(bus.o_err), VW'(1));
        repeat (5) @(negedge clk);
        checkOutput("stray noVector", VW'(vecCount), VW'(pushedCount));
        checkOutput("stray validLow", VW'(bus.o_valid), VW'(0));

        $display("[TB] async reset with a full buffer and a partial group");
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        applyGroup(2'd1, 2'd0, 50, 2);
        applyStimulus(1'b1, 2'd3, 2'd1, mkBeat(60));
        applyStimulus(1'b0, 2'd3, 2'd1, mkBeat(64));
        checkOutput("rst preValid", VW'(bus.o_valid), VW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst validDropped", VW'(bus.o_valid), VW'(0));
        checkOutput("rst readyBack", VW'(bus.o_ready), VW'(1));
        expQ.delete();
        pushedCount--;
        @(negedge clk);
        rst_n       = 1'b1;
        bus.i_ready = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("rst noVector", VW'(vecCount), VW'(pushedCount));
        checkOutput("rst validLow", VW'(bus.o_valid), VW'(0));

`ifdef RE_PACK_ZERO_EN
        $display("[TB] zero group in one beat");
        ex.data = '0;
        ex.ts   = 2'd2;
        ex.tq   = 2'd1;
        expQ.push_back(ex);
        pushedCount++;
        bus.i_zero = 1'b1;
        applyStimulus(1'b1, 2'd2, 2'd1, mkBeat(99));
        bus.i_zero = 1'b0;
        checkOutput("zero validNext", VW'(bus.o_valid), VW'(1));
        checkOutput("zero transize", VW'(bus.o_transize), VW'(2));
        waitDrain("zero drained");
`else
        $display("[TB] zero-valued 16x16 group needs four beats");
        ex.data = '0;
        ex.ts   = 2'd2;
        ex.tq   = 2'd1;
        expQ.push_back(ex);
        pushedCount++;
        applyStimulus(1'b1, 2'd2, 2'd1, '0);
        checkOutput("zero noEarlyValid", VW'(bus.o_valid), VW'(0));
        for (int b = 1; b < 4; b++)
            applyStimulus(1'b0, 2'd2, 2'd1, '0);
        checkOutput("zero validAfter4", VW'(bus.o_valid), VW'(1));
        checkOutput("zero transize", VW'(bus.o_transize), VW'(2));
        waitDrain("zero drained");
`endif

        checkOutput("total vectors", VW'(vecCount), VW'(pushedCount));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
